tx_pkt_gen: RTL and testbench



---
 rtl/tx_pkt_gen.sv | 192 +++++++++++++++++++
 tb/tb_tx_pkt_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_gen.sv
// Synthetic AXI-stream packet source: emits a configured number of fixed-length packets
// with an idle gap between them; each beat carries {beat index, packet sequence number}.
module tx_pkt_gen #(
    parameter int DATA_W = 256,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       cfg_pkt_num,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    input  logic [LEN_W-1:0]  cfg_gap,
    output logic [DATA_W-1:0] tx_tdata,
    output logic              tx_tvalid,
    output logic              tx_tlast,
    input  logic              tx_tready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       tx_pkt_sent
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  gap_q, gap_d;
    logic [31:0]       num_q, num_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0]       pkt_sent_q, pkt_sent_d;
    logic              abort_req_q, abort_req_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              handshake;
    logic              last_beat;
    logic              stop_req;
    logic [31:0]       pkt_next;
    logic [LEN_W-1:0]  beat_inc;
    logic [LEN_W-1:0]  len_eff;

    function automatic logic [DATA_W-1:0] beat_word(input logic [31:0] pkt,
                                                    input logic [LEN_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w        = '0;
        w[31:0]  = pkt;
        w[47:32] = 16'(idx);
        return w;
    endfunction

    assign handshake = tvalid_q & tx_tready;
    assign last_beat = (beat_q == len_q - LEN_W'(1));
    // A short abort pulse must still end the run, so it is remembered until the packet boundary.
    assign stop_req  = abort | abort_req_q;
    assign pkt_next  = pkt_sent_q + 32'd1;
    assign beat_inc  = beat_q + LEN_W'(1);
    assign len_eff   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        gap_d       = gap_q;
        num_d       = num_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_sent_d  = pkt_sent_q;
        abort_req_d = abort_req_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = len_eff;
                    gap_d       = cfg_gap;
                    num_d       = cfg_pkt_num;
                    pkt_sent_d  = '0;
                    beat_d      = '0;
                    gap_cnt_d   = '0;
                    abort_req_d = 1'b0;
                    tdata_d     = beat_word(32'd0, '0);
                    tvalid_d    = 1'b1;
                    tlast_d     = (len_eff == LEN_W'(1));
                    busy_d      = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    abort_req_d = 1'b1;
                end
                if (handshake) begin
                    if (!last_beat) begin
                        beat_d  = beat_inc;
                        tdata_d = beat_word(pkt_sent_q, beat_inc);
                        tlast_d = (beat_inc == len_q - LEN_W'(1));
                    end else begin
                        pkt_sent_d = pkt_next;
                        beat_d     = '0;
                        if (stop_req || (num_q != 32'd0 && pkt_next == num_q)) begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            tdata_d  = '0;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = ST_FIN;
                        end else if (gap_q != '0) begin
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            tdata_d   = '0;
                            gap_cnt_d = LEN_W'(1);
                            state_d   = ST_GAP;
                        end else begin
                            tdata_d = beat_word(pkt_next, '0);
                            tlast_d = (len_q == LEN_W'(1));
                        end
                    end
                end
            end
            ST_GAP: begin
                if (stop_req) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else if (gap_cnt_q == gap_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = beat_word(pkt_sent_q, '0);
                    tlast_d  = (len_q == LEN_W'(1));
                    state_d  = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + LEN_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= LEN_W'(1);
            gap_q       <= '0;
            num_q       <= '0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            pkt_sent_q  <= '0;
            abort_req_q <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            num_q       <= num_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_sent_q  <= pkt_sent_d;
            abort_req_q <= abort_req_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_tdata    = tdata_q;
    assign tx_tvalid   = tvalid_q;
    assign tx_tlast    = tlast_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tx_pkt_sent = pkt_sent_q;

endmodule

// File: tb/tb_tx_pkt_gen.sv
// Scoreboard bench for tx_pkt_gen: stimulus pushes the expected beat list of each run,
// an independent negedge monitor pops and compares every handshaken beat.
module tb_tx_pkt_gen;

    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [31:0]       cfg_pkt_num;
    logic [LEN_W-1:0]  cfg_pkt_len;
    logic [LEN_W-1:0]  cfg_gap;
    logic [DATA_W-1:0] tx_tdata;
    logic              tx_tvalid;
    logic              tx_tlast;
    logic              tx_tready;
    logic              busy;
    logic              done;
    logic [31:0]       tx_pkt_sent;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_gap  = 0;
    int gap_seen = 0;
    bit gap_track = 0;
    bit hold_valid = 0;
    bit rand_ready = 0;
    logic [DATA_W-1:0] held_data;
    logic              held_last;

    tx_pkt_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_gap     (cfg_gap),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tlast    (tx_tlast),
        .tx_tready   (tx_tready),
        .busy        (busy),
        .done        (done),
        .tx_pkt_sent (tx_pkt_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: packet p, beat i carries p in bits 31:0 and i in bits 47:32.
    task automatic pushPackets(input int n_pkts, input int len);
        beat_t b;
        int l;
        l = (len == 0) ? 1 : len;
        for (int p = 0; p < n_pkts; p++) begin
            for (int i = 0; i < l; i++) begin
                b.data        = '0;
                b.data[31:0]  = 32'(p);
                b.data[47:32] = 16'(i);
                b.last        = (i == l - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor: beat ordering, stall stability and inter-packet gap length.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 0;
            gap_track  = 0;
        end else begin
            if (done) done_cnt++;
            if (hold_valid)
                checkOutput("stall_stable", {1'b0, tx_tvalid, tx_tlast, tx_tdata}, {1'b0, 1'b1, held_last, held_data});
            if (gap_track) begin
                if (tx_tvalid) begin
                    checkOutput("gap_len", 260'(gap_seen), 260'(exp_gap));
                    gap_track = 0;
                end else begin
                    gap_seen++;
                end
            end
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got %0h expected no beat", tx_tdata);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("beat_data", 260'(tx_tdata), 260'(cur.data));
                    checkOutput("beat_last", 260'(tx_tlast), 260'(cur.last));
                    if (tx_tlast && exp_q.size() != 0) begin
                        gap_track = 1;
                        gap_seen  = 0;
                    end
                end
                hold_valid = 0;
            end else if (tx_tvalid) begin
                hold_valid = 1;
                held_data  = tx_tdata;
                held_last  = tx_tlast;
            end else begin
                hold_valid = 0;
            end
        end
    end

    task automatic applyStimulus(input int num, input int len, input int gap, input int model_pkts);
        cfg_pkt_num = 32'(num);
        cfg_pkt_len = LEN_W'(len);
        cfg_gap     = LEN_W'(gap);
        exp_gap     = gap;
        pushPackets(model_pkts, len);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // Scramble config after acceptance; the run must not notice.
        cfg_pkt_num = 32'd7;
        cfg_pkt_len = LEN_W'(9);
        cfg_gap     = LEN_W'(3);
        @(negedge clk);
        checkOutput("start_busy", 260'(busy), 260'(1));
        checkOutput("start_tvalid", 260'(tx_tvalid), 260'(1));
    endtask

    task automatic waitForDone(input int exp_sent, input int budget);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end else begin
            checkOutput("done_busy", 260'(busy), 260'(0));
            checkOutput("pkt_sent", 260'(tx_pkt_sent), 260'(exp_sent));
            checkOutput("left_beats", 260'(exp_q.size()), 260'(0));
            @(negedge clk);
            checkOutput("done_pulse", 260'(done), 260'(0));
        end
    endtask

    task automatic waitBeat(input int seq, input int idx, input int budget);
        int cyc = 0;
        while (!(tx_tvalid === 1'b1 && tx_tdata[31:0] == 32'(seq) && tx_tdata[47:32] == 16'(idx)) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= budget) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL beat_timeout: got no beat seq %0d idx %0d expected one", seq, idx);
        end
    endtask

    initial begin
        int dones_before;
        rst_n       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_pkt_num = '0;
        cfg_pkt_len = '0;
        cfg_gap     = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {224'd0, tx_tvalid, tx_tlast, busy, done, tx_pkt_sent},
                    {224'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        checkOutput("reset_tdata", 260'(tx_tdata), 260'(0));
        #2 rst_n = 1'b1;

        $display("[TB] three back-to-back packets of 4 beats");
        applyStimulus(3, 4, 0, 3);
        waitForDone(3, 100);

        $display("[TB] two single-beat packets with gap 5");
        applyStimulus(2, 1, 5, 2);
        waitForDone(2, 100);

        $display("[TB] one 3-beat packet under random backpressure");
        rand_ready = 1;
        applyStimulus(1, 3, 0, 1);
        waitForDone(1, 200);
        rand_ready = 0;

        $display("[TB] random runs under backpressure");
        for (int r = 0; r < 3; r++) begin
            int n, l, g;
            n = $urandom_range(1, 4);
            l = $urandom_range(0, 5);
            g = $urandom_range(0, 3);
            rand_ready = 1;
            applyStimulus(n, l, g, n);
            waitForDone(n, 400);
            rand_ready = 0;
        end

        $display("[TB] continuous run aborted during packet 5");
        applyStimulus(0, 2, 0, 6);
        waitBeat(5, 0, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitForDone(6, 50);

        $display("[TB] reset during beat 2 of an 8-beat packet");
        applyStimulus(1, 8, 0, 1);
        waitBeat(0, 2, 50);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctl", {224'd0, tx_tvalid, tx_tlast, busy, done, tx_pkt_sent},
                    {224'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        checkOutput("async_reset_tdata", 260'(tx_tdata), 260'(0));
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1, 2, 0, 1);
        waitForDone(1, 50);

        $display("[TB] zero length with start held while busy");
        cfg_pkt_num = 32'd1;
        cfg_pkt_len = '0;
        cfg_gap     = '0;
        pushPackets(1, 0);
        dones_before = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("single_done", 260'(done_cnt - dones_before), 260'(1));
        checkOutput("single_sent", 260'(tx_pkt_sent), 260'(1));
        checkOutput("single_left", 260'(exp_q.size()), 260'(0));
        checkOutput("single_idle", 260'(busy), 260'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
